// File: rtl/ado_detector_if.sv
// ado_detector_if: sample-stream and result bundle for the ADO spike detector.
// master drives in_valid/data_in/retrain and receives the outputs; slave is the detector.
interface ado_detector_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] data_in;
    logic                     retrain;
    logic                     out_valid;
    logic [DATA_W:0]          ado_out;
    logic                     spike_detected;
    logic [DATA_W:0]          threshold_out;
    logic                     training;

    modport master (
        output in_valid, data_in, retrain,
        input  out_valid, ado_out, spike_detected, threshold_out, training
    );

    modport slave (
        input  in_valid, data_in, retrain,
        output out_valid, ado_out, spike_detected, threshold_out, training
    );
endinterface

// File: rtl/ado_detector.sv
// ado_detector: |x[n]-x[n-DELAY]| spike detector with trained threshold and refractory hold-off.
// Ports: clk, rst (async, active high), bus (ado_detector_if.slave: in_valid, data_in, retrain,
// out_valid, ado_out, spike_detected, threshold_out, training). Optional macro ADO_SPIKE_CNT_EN
// adds output spike_count[15:0], a saturating count of reported spikes.
module ado_detector #(
    parameter int DATA_W     = 16,
    parameter int DELAY      = 3,
    parameter int TRAIN_LOG2 = 8,
    parameter int THR_SHIFT  = 2,
    parameter int REFRACT    = 16,
    parameter int THR_INIT   = 500
) (
    input  logic                clk,
    input  logic                rst,
    ado_detector_if.slave       bus
`ifdef ADO_SPIKE_CNT_EN
    ,
    output logic [15:0]         spike_count
`endif
);
    localparam int AW    = DATA_W + 1;
    localparam int ACC_W = AW + TRAIN_LOG2;
    localparam int TC_W  = (TRAIN_LOG2 > 0) ? TRAIN_LOG2 : 1;
    localparam int FC_W  = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
    localparam int RC_W  = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;
    localparam int TW    = AW + THR_SHIFT;

    typedef enum logic [1:0] {
        S_FILL,
        S_TRAIN,
        S_RUN,
        S_REFR
    } state_t;

    state_t                   state_q;
    logic signed [DATA_W-1:0] dly_q [DELAY];
    logic [FC_W-1:0]          fcnt_q;
    logic [TC_W-1:0]          tcnt_q;
    logic [RC_W-1:0]          rcnt_q;
    logic [ACC_W-1:0]         acc_q;
    logic                     out_valid_q;
    logic [AW-1:0]            ado_q;
    logic                     spike_q;
    logic [AW-1:0]            thr_q;
    logic                     training_q;

    logic signed [AW-1:0]     diff;
    logic [AW-1:0]            ado;
    logic [ACC_W-1:0]         acc_sum;
    logic [AW-1:0]            mean;
    logic [TW-1:0]            thr_wide;
    logic [AW-1:0]            thr_new;
    logic                     train_done;
    logic                     retrain_ok;

    // Sign-extend one bit so the difference and its magnitude never wrap.
    assign diff = {bus.data_in[DATA_W-1], bus.data_in}
                - {dly_q[DELAY-1][DATA_W-1], dly_q[DELAY-1]};
    assign ado  = diff[AW-1] ? AW'(-diff) : AW'(diff);

    assign acc_sum    = acc_q + ACC_W'(ado);
    assign mean       = AW'(acc_sum >> TRAIN_LOG2);
    assign thr_wide   = TW'(mean) << THR_SHIFT;
    // Anything shifted past the output width saturates to all-ones.
    assign thr_new    = ((thr_wide >> AW) != '0) ? '1 : thr_wide[AW-1:0];
    assign train_done = (tcnt_q == TC_W'((1 << TRAIN_LOG2) - 1));
    assign retrain_ok = bus.retrain && (state_q != S_FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
            fcnt_q      <= '0;
            tcnt_q      <= '0;
            rcnt_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            ado_q       <= '0;
            spike_q     <= 1'b0;
            thr_q       <= AW'(THR_INIT);
            training_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                dly_q[0] <= bus.data_in;
                for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
            end
            if (bus.in_valid && state_q != S_FILL) begin
                out_valid_q <= 1'b1;
                ado_q       <= ado;
                spike_q     <= 1'b0;
            end
            if (retrain_ok) begin
                // Delay line and threshold survive a retrain.
                state_q    <= S_TRAIN;
                acc_q      <= '0;
                tcnt_q     <= '0;
                rcnt_q     <= '0;
                training_q <= 1'b1;
            end else if (bus.in_valid) begin
                unique case (state_q)
                    S_FILL: begin
                        if (fcnt_q == FC_W'(DELAY - 1)) state_q <= S_TRAIN;
                        else fcnt_q <= fcnt_q + 1'b1;
                    end
                    S_TRAIN: begin
                        acc_q  <= acc_sum;
                        tcnt_q <= tcnt_q + 1'b1;
                        if (train_done) begin
                            thr_q      <= thr_new;
                            acc_q      <= '0;
                            state_q    <= S_RUN;
                            training_q <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (ado > thr_q) begin
                            spike_q <= 1'b1;
                            if (REFRACT > 0) begin
                                state_q <= S_REFR;
                                rcnt_q  <= RC_W'(REFRACT);
                            end
                        end
                    end
                    S_REFR: begin
                        // The sample that takes the counter to zero is still suppressed.
                        rcnt_q <= rcnt_q - 1'b1;
                        if (rcnt_q == RC_W'(1)) state_q <= S_RUN;
                    end
                endcase
            end
        end
    end

`ifdef ADO_SPIKE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (retrain_ok) begin
            cnt_q <= '0;
        end else if (out_valid_q && spike_q && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign spike_count = cnt_q;
`endif

    assign bus.out_valid      = out_valid_q;
    assign bus.ado_out        = ado_q;
    assign bus.spike_detected = spike_q;
    assign bus.threshold_out  = thr_q;
    assign bus.training       = training_q;
endmodule

// File: doc/ado_detector.md
Name: ado_detector

Overview:
- Parametrised absolute-difference-operator (ADO) spike detector for one neural channel; successor to the fixed 4-tap ADO block.
- Computes |x[n] − x[n−DELAY]| per valid sample, learns its threshold from a training window, and applies a refractory hold-off after each spike.
- Sits between the sample stream (valid-qualified) and downstream event logic.

Parameters:
- DATA_W, 16, signed sample width.
- DELAY, 3, tap distance in valid samples (≥1).
- TRAIN_LOG2, 8, training window = 2^TRAIN_LOG2 ADO values.
- THR_SHIFT, 2, threshold = mean ADO << THR_SHIFT.
- REFRACT, 16, valid samples suppressed after a spike (0 = none).
- THR_INIT, 500, threshold value before the first training completes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  data_in is a new sample this cycle.
- data_in  in  DATA_W  signed sample.
- retrain  in  1  single-cycle pulse: restart training.
- out_valid  out  1  registered; ado_out/spike_detected valid.
- ado_out  out  DATA_W+1  unsigned |x[n] − x[n−DELAY]|.
- spike_detected  out  1  registered spike flag, qualified by out_valid.
- threshold_out  out  DATA_W+1  active threshold.
- training  out  1  high in FILL and TRAIN.

Behaviour:
- Reset values: out_valid=0, ado_out=0, spike_detected=0, threshold_out=THR_INIT, training=1. Delay line, counters and accumulator are 0. State is FILL.
- Only cycles with in_valid=1 advance anything. With in_valid=0, all state holds and out_valid=0.
- ADO arithmetic: sign-extend to DATA_W+1 bits before subtracting, then take the absolute value. No overflow and no saturation; the full range is 0..2^DATA_W−1.
- Latency: a sample accepted on cycle t produces out_valid, ado_out and spike_detected on cycle t+1.
- FILL:
  - The first DELAY valid samples only load the delay line; out_valid stays 0.
  - After the DELAY-th sample, go to TRAIN.
- TRAIN:
  - out_valid=1 per sample; spike_detected forced 0.
  - Each ADO is added to an accumulator of width DATA_W+1+TRAIN_LOG2.
  - On the 2^TRAIN_LOG2-th value, threshold = (acc >> TRAIN_LOG2) << THR_SHIFT, saturated to all-ones of DATA_W+1 bits. The new threshold_out takes effect the following cycle.
  - Go to RUN.
- RUN:
  - spike_detected = (ado > threshold_out), strict; equality is not a spike.
  - On a spike with REFRACT>0, go to REFRACT with the counter loaded to REFRACT.
- REFRACT:
  - ADO is still output, but spike_detected is forced 0.
  - The counter decrements per valid sample; when it reaches 0, go to RUN.
  - The sample on which the counter reaches 0 is still suppressed.
- retrain pulse (any state after FILL):
  - Next state is TRAIN; accumulator and train counter cleared; refractory counter cleared.
  - The delay line is kept.
  - threshold_out keeps its old value until training completes.
  - If in_valid coincides with retrain, the sample enters the delay line and is output with spike_detected=0, but is not accumulated.
- retrain during FILL is ignored.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro: ADO_SPIKE_CNT_EN.
- Defined:
  - Adds output port spike_count [15:0], registered.
  - Increments on each cycle where out_valid and spike_detected are both 1; saturates at 0xFFFF.
  - Cleared by rst and by an accepted retrain.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream → all outputs at reset values immediately; threshold_out=500, training=1, out_valid=0.
- Training (DELAY=3, TRAIN_LOG2=2, THR_SHIFT=1): ramp 0,10,20,… with in_valid every cycle → no out_valid for the first 3 samples; then ado_out=30 ×4; threshold_out=60; training=0.
- Detection and refractory (REFRACT=3, ramp continued):
  - ADO 30 → no spike.
  - Inject +100 step → ado 130 → spike_detected=1 one cycle later.
  - Next 3 valid samples with ado>60 → spike_detected=0.
  - 4th such sample → 1.
  - ado exactly 60 → 0.
- Valid gaps: drop in_valid for 5 cycles mid-refractory → out_valid=0 and counter unchanged; suppression resumes correctly afterwards.
- Retrain: pulse retrain in RUN, then ramp step 20 → threshold_out stays 60 during training, becomes 120 after 4 values; coincident sample not accumulated.
- Extremes: data −32768 then 32767 at distance DELAY → ado_out=65535, spike_detected=1; with ADO_SPIKE_CNT_EN, spike_count increments by 1 per spike.
